// File: rtl/nv_cdc_pkg.sv
// Shared definitions for the nv_cdc req/ack handshake transmitter and receiver.
package nv_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdc_state_e;

  localparam int unsigned CDC_SYNC_STAGES = 3;

endpackage

// File: rtl/sync3d.sv
// Multi-flop level synchronizer without reset; output lags d by CDC_SYNC_STAGES edges.
module sync3d
  import nv_cdc_pkg::*;
(
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [CDC_SYNC_STAGES-1:0] sync_q;
  logic [CDC_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[CDC_SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  assign q = sync_q[CDC_SYNC_STAGES-1];

endmodule

// File: rtl/nv_cdc_hs_tx.sv
// Source side of a 4-phase req/ack CDC handshake: input FIFO, launch FSM,
// ack synchronizer and a sticky phase watchdog.
module nv_cdc_hs_tx
  import nv_cdc_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [DW-1:0] src_data,
  output logic          cdc_req,
  output logic [DW-1:0] cdc_data,
  input  logic          cdc_ack,
  output logic          busy,
  output logic          done,
  output logic          err_timeout
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX   = '1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
  localparam logic           WD_EN    = (TIMEOUT != 0);

  cdc_state_e    state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [1:0]    settle_q, settle_d;
  logic          src_ready_q, src_ready_d;
  logic          cdc_req_q, cdc_req_d;
  logic [DW-1:0] cdc_data_q, cdc_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic ack_s, push, pop, empty, full_d, settled;

  sync3d u_ack_sync (
    .clk (nvdla_core_clk),
    .d   (cdc_ack),
    .q   (ack_s)
  );

  assign settled = (settle_q == 2'd3);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // src_ready_q already encodes ~full, so a push never lands on a full FIFO.
  assign push    = src_valid & src_ready_q;

  always_comb begin
    state_d    = state_q;
    cdc_req_d  = cdc_req_q;
    cdc_data_d = cdc_data_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !ack_s && settled) begin
          state_d    = REQ;
          pop        = 1'b1;
          cdc_data_d = mem_q[rd_ptr_q[AW-1:0]];
          cdc_req_d  = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d   = REL;
          cdc_req_d = 1'b0;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    src_ready_d = !full_d && settled;
    settle_d    = settled ? settle_q : settle_q + 2'd1;

    // Phase watchdog: restarts on every transition, idles at zero in IDLE.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
    err_d = err_q | (WD_EN && (wd_d == WD_LIMIT));
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= src_data;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      settle_q    <= '0;
      src_ready_q <= 1'b0;
      cdc_req_q   <= 1'b0;
      cdc_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      settle_q    <= settle_d;
      src_ready_q <= src_ready_d;
      cdc_req_q   <= cdc_req_d;
      cdc_data_q  <= cdc_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  assign src_ready   = src_ready_q;
  assign cdc_req     = cdc_req_q;
  assign cdc_data    = cdc_data_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_nv_cdc_hs_tx.sv
// Self-checking bench for nv_cdc_hs_tx with a far-side ack model and an
// occupancy/order scoreboard.
module tb_nv_cdc_hs_tx;

  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          cdc_ack = 1'b0;
  logic          src_ready, cdc_req, busy, done, err_timeout;
  logic [DW-1:0] cdc_data;
  logic          t0_src_ready, t0_cdc_req, t0_busy, t0_done, t0_err;
  logic [DW-1:0] t0_cdc_data;

  always #5 clk = ~clk;

  nv_cdc_hs_tx #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .cdc_req(cdc_req), .cdc_data(cdc_data), .cdc_ack(cdc_ack),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  nv_cdc_hs_tx #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(0)) dut_t0 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .src_valid(src_valid), .src_ready(t0_src_ready), .src_data(src_data),
    .cdc_req(t0_cdc_req), .cdc_data(t0_cdc_data), .cdc_ack(cdc_ack),
    .busy(t0_busy), .done(t0_done), .err_timeout(t0_err)
  );

  int checks = 0;
  int failures = 0;

  // Far side: echo mode returns req delayed by far_dly-1 edges; manual mode drives man_ack.
  int         far_mode = 0;
  int         far_dly  = 2;
  logic       man_ack  = 1'b0;
  logic [7:0] req_hist = '0;
  always @(posedge clk) begin
    #3;
    req_hist = {req_hist[6:0], cdc_req};
    cdc_ack  = (far_mode != 0) ? req_hist[far_dly-1] : man_ack;
  end

  // Monitor: launches, completions, data stability, and FIFO occupancy model.
  int            cyc = 0, launch_cnt = 0, done_cnt = 0;
  int            overlap_err = 0, stab_err = 0, rdy_err = 0;
  int            rst_age = 0, occ = 0, last_rise = 0, last_fall = 0;
  bit            open_hs = 1'b0, push_e = 1'b0, rst_e = 1'b1;
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] launched[$];
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    push_e = src_valid & src_ready;
    rst_e  = rst;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_e) begin
      occ = 0; open_hs = 1'b0; rst_age = 0;
    end else begin
      if (rst_age < 100) rst_age++;
      if (push_e) occ++;
      if (cdc_req && !prev_req) begin
        occ--;
        launched.push_back(cdc_data);
        launch_cnt++;
        last_rise = cyc;
        if (open_hs) overlap_err++;
        open_hs = 1'b1;
      end else if (cdc_data !== prev_data) begin
        stab_err++;
      end
      if (!cdc_req && prev_req) last_fall = cyc;
      if (done) begin done_cnt++; open_hs = 1'b0; end
      if (src_ready !== ((rst_age >= 4) && (occ < int'(DEPTH)))) rdy_err++;
    end
    prev_req  = cdc_req;
    prev_data = cdc_data;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic ack_lvl);
    far_mode  = 0;
    man_ack   = ack_lvl;
    src_valid = 1'b0;
    rst       = 1'b1;
    ticks(6);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int n;
    n = 0;
    while (!src_ready && n < 200) begin tick(); n++; end
    checks++;
    if (!src_ready) begin
      failures++;
      $display("FAIL push_wait src_ready=%b required=1", src_ready);
    end else begin
      src_valid = 1'b1;
      src_data  = w;
      tick();
      src_valid = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || open_hs) && n < bound) begin tick(); n++; end
    checks++;
    if (busy || open_hs) begin
      failures++;
      $display("FAIL idle_wait busy=%b open=%b required=0", busy, open_hs);
    end
  endtask

  task automatic check_order(input string name);
    checks++;
    if (launched.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count launched=%0d required=%0d", name, launched.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      checks++;
      if (launched[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_word%0d got=%h required=%h", name, i, launched[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks += 6;
    if (cdc_req !== 1'b0)     begin failures++; $display("FAIL rst_req got=%b required=0", cdc_req); end
    if (cdc_data !== '0)      begin failures++; $display("FAIL rst_data got=%h required=0", cdc_data); end
    if (done !== 1'b0)        begin failures++; $display("FAIL rst_done got=%b required=0", done); end
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err got=%b required=0", err_timeout); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (src_ready !== 1'b0)   begin failures++; $display("FAIL rst_ready got=%b required=0", src_ready); end
    ticks(3);
    checks++;
    if (src_ready !== 1'b0) begin failures++; $display("FAIL settle3_ready got=%b required=0", src_ready); end
    tick();
    checks++;
    if (src_ready !== 1'b1) begin failures++; $display("FAIL settle4_ready got=%b required=1", src_ready); end
  endtask

  task automatic test_single();
    int n, d0, s0;
    far_mode = 1; far_dly = 2;
    launched.delete(); exp_q.delete();
    d0 = done_cnt; s0 = stab_err;
    push_word(32'hA5A5_0001);
    n = cyc;
    tick();
    checks++;
    if (cdc_req !== 1'b1 || last_rise != n + 1) begin
      failures++; $display("FAIL single_rise req=%b rise_at=%0d required=%0d", cdc_req, last_rise, n + 1);
    end
    for (int i = 0; i < 30 && cdc_req; i++) tick();
    checks += 2;
    if (last_fall - last_rise != 5) begin
      failures++; $display("FAIL single_fall got=%0d edges required=5", last_fall - last_rise);
    end
    if (cdc_data !== 32'hA5A5_0001) begin
      failures++; $display("FAIL single_data got=%h required=a5a50001", cdc_data);
    end
    wait_idle(40);
    checks += 2;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_done got=%0d required=1", done_cnt - d0); end
    if (stab_err != s0)     begin failures++; $display("FAIL single_stable got=%0d required=0", stab_err - s0); end
    check_order("single");
  endtask

  task automatic test_back_to_back();
    int i, n, d0, o0, r0, t0;
    logic was_rdy;
    logic [DW-1:0] w [3];
    far_mode = 1; far_dly = 2;
    launched.delete(); exp_q.delete();
    d0 = done_cnt; o0 = overlap_err; r0 = rdy_err;
    for (int k = 0; k < 3; k++) w[k] = $urandom;
    i = 0; n = 0; t0 = cyc;
    while (i < 3 && n < 100) begin
      src_valid = 1'b1;
      src_data  = w[i];
      was_rdy   = src_ready;
      tick();
      if (was_rdy) begin exp_q.push_back(w[i]); i++; end
      n++;
    end
    src_valid = 1'b0;
    checks += 2;
    if (cyc - t0 != 3) begin failures++; $display("FAIL b2b_cycles got=%0d required=3", cyc - t0); end
    if (src_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b required=0", src_ready); end
    wait_idle(200);
    checks += 3;
    if (done_cnt - d0 != 3)    begin failures++; $display("FAIL b2b_done got=%0d required=3", done_cnt - d0); end
    if (overlap_err != o0)     begin failures++; $display("FAIL b2b_overlap got=%0d required=0", overlap_err - o0); end
    if (rdy_err != r0)         begin failures++; $display("FAIL b2b_ready_model got=%0d required=0", rdy_err - r0); end
    check_order("b2b");
  endtask

  task automatic test_random();
    int d0, o0, r0, s0;
    for (int round = 0; round < 2; round++) begin
      far_mode = 1; far_dly = $urandom_range(1, 4);
      launched.delete(); exp_q.delete();
      d0 = done_cnt; o0 = overlap_err; r0 = rdy_err; s0 = stab_err;
      for (int k = 0; k < 16; k++) begin
        ticks($urandom_range(0, 3));
        push_word($urandom);
      end
      wait_idle(400);
      checks += 4;
      if (done_cnt - d0 != 16) begin failures++; $display("FAIL rnd_done got=%0d required=16", done_cnt - d0); end
      if (overlap_err != o0)   begin failures++; $display("FAIL rnd_overlap got=%0d required=0", overlap_err - o0); end
      if (rdy_err != r0)       begin failures++; $display("FAIL rnd_ready_model got=%0d required=0", rdy_err - r0); end
      if (stab_err != s0)      begin failures++; $display("FAIL rnd_stable got=%0d required=0", stab_err - s0); end
      check_order("rnd");
    end
  endtask

  task automatic test_timeout();
    int d0;
    do_reset(1'b0);
    ticks(4);
    launched.delete(); exp_q.delete();
    d0 = done_cnt;
    push_word($urandom);
    tick();
    checks++;
    if (cdc_req !== 1'b1) begin failures++; $display("FAIL to_launch got=%b required=1", cdc_req); end
    ticks(15);
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b required=0", err_timeout); end
    tick();
    checks += 2;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_at16 got=%b required=1", err_timeout); end
    if (cdc_req !== 1'b1)     begin failures++; $display("FAIL to_req_held got=%b required=1", cdc_req); end
    man_ack = 1'b1;
    for (int i = 0; i < 20 && cdc_req; i++) tick();
    man_ack = 1'b0;
    wait_idle(20);
    checks += 2;
    if (done_cnt - d0 != 1)   begin failures++; $display("FAIL to_done got=%0d required=1", done_cnt - d0); end
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b required=1", err_timeout); end
    check_order("to");
  endtask

  task automatic test_no_timeout();
    do_reset(1'b0);
    ticks(4);
    launched.delete(); exp_q.delete();
    push_word($urandom);
    ticks(5000);
    checks += 3;
    if (t0_err !== 1'b0)      begin failures++; $display("FAIL t0_err got=%b required=0", t0_err); end
    if (t0_cdc_req !== 1'b1)  begin failures++; $display("FAIL t0_req got=%b required=1", t0_cdc_req); end
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL t16_err got=%b required=1", err_timeout); end
    man_ack = 1'b1;
    for (int i = 0; i < 20 && cdc_req; i++) tick();
    man_ack = 1'b0;
    wait_idle(20);
    check_order("t0");
  endtask

  task automatic test_reset_in_req();
    int l0;
    logic [DW-1:0] w3;
    far_mode = 0; man_ack = 1'b0;
    push_word($urandom);
    tick();
    src_valid = 1'b1; src_data = $urandom; man_ack = 1'b1;
    tick();
    src_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks += 2;
    if (cdc_req !== 1'b0) begin failures++; $display("FAIL rreq_req got=%b required=0", cdc_req); end
    if (busy !== 1'b0)    begin failures++; $display("FAIL rreq_flush busy=%b required=0", busy); end
    ticks(5);
    rst = 1'b0;
    ticks(3);
    checks++;
    if (src_ready !== 1'b0) begin failures++; $display("FAIL rreq_ready3 got=%b required=0", src_ready); end
    tick();
    checks++;
    if (src_ready !== 1'b1) begin failures++; $display("FAIL rreq_ready4 got=%b required=1", src_ready); end
    launched.delete(); exp_q.delete();
    w3 = $urandom;
    push_word(w3);
    l0 = launch_cnt;
    ticks(10);
    checks++;
    if (cdc_req !== 1'b0 || launch_cnt != l0) begin
      failures++; $display("FAIL rreq_stale req=%b launches=%0d required=0", cdc_req, launch_cnt - l0);
    end
    man_ack = 1'b0;
    for (int i = 0; i < 10 && !cdc_req; i++) tick();
    checks += 2;
    if (cdc_req !== 1'b1) begin failures++; $display("FAIL rreq_launch got=%b required=1", cdc_req); end
    if (cdc_data !== w3)  begin failures++; $display("FAIL rreq_data got=%h required=%h", cdc_data, w3); end
    man_ack = 1'b1;
    for (int i = 0; i < 20 && cdc_req; i++) tick();
    man_ack = 1'b0;
    wait_idle(20);
    check_order("rreq");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_timeout();
    test_no_timeout();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit cycles=%0d required=finish", cyc);
    $fatal(1, "time limit");
  end

endmodule
